// File: rtl/comparator_search4.sv
// comparator_search4: binary-search driver for a 4-bit magnitude comparator.
// Drives B (guess), consumes {G,E,L}, and locates A in at most 5 compares.
module comparator_search4 #(
   parameter int unsigned SETTLE_CYC = 0
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       start,
   input  logic [2:0] cmp_r,
   output logic [3:0] guess,
   output logic       busy,
   output logic       done,
   output logic [3:0] found,
   output logic [2:0] steps,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_CMP,
      S_DONE,
      S_ERR
   } state_t;

   localparam bit         HAS_WAIT = (SETTLE_CYC > 0);
   localparam logic [1:0] WLOAD    = HAS_WAIT ? 2'(SETTLE_CYC - 1) : 2'd0;

   state_t     state, next_state;
   logic [4:0] lo, hi, n_lo, n_hi;
   logic [4:0] mid_sum;
   logic [1:0] wcnt, n_wcnt;
   logic [3:0] n_guess, n_found;
   logic [2:0] n_steps;

   // State register
   always_ff @(posedge clk) begin
      if (!nRst) state <= S_IDLE;
      else       state <= next_state;
   end

   // Search datapath registers (bounds, settle counter, guess, result)
   always_ff @(posedge clk) begin
      if (!nRst) begin
         lo    <= '0;
         hi    <= 5'd15;
         wcnt  <= '0;
         guess <= '0;
         found <= '0;
         steps <= '0;
      end else begin
         lo    <= n_lo;
         hi    <= n_hi;
         wcnt  <= n_wcnt;
         guess <= n_guess;
         found <= n_found;
         steps <= n_steps;
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      next_state = state;
      n_lo       = lo;
      n_hi       = hi;
      n_wcnt     = wcnt;
      n_guess    = guess;
      n_found    = found;
      n_steps    = steps;
      mid_sum    = lo + hi;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               n_lo    = '0;
               n_hi    = 5'd15;
               n_guess = 4'd7;
               n_steps = '0;
               n_wcnt  = WLOAD;
               next_state = HAS_WAIT ? S_WAIT : S_CMP;
            end
         end
         S_WAIT: begin
            if (wcnt == 2'd0) next_state = S_CMP;
            else              n_wcnt     = wcnt - 2'd1;
         end
         S_CMP: begin
            n_steps = steps + 3'd1;
            unique case (cmp_r)
               3'b010: begin
                  n_found    = guess;
                  next_state = S_DONE;
               end
               3'b100: begin
                  if (guess == 4'd15) next_state = S_ERR;
                  else                n_lo       = {1'b0, guess} + 5'd1;
               end
               3'b001: begin
                  if (guess == 4'd0) next_state = S_ERR;
                  else               n_hi       = {1'b0, guess} - 5'd1;
               end
               default: next_state = S_ERR;
            endcase
            // A G/L outcome that did not already fault narrows the window;
            // a crossed window or a sixth compare means an inconsistent comparator.
            if (next_state == S_CMP && (cmp_r == 3'b100 || cmp_r == 3'b001)) begin
               mid_sum = n_lo + n_hi;
               if (n_lo > n_hi || steps == 3'd4) begin
                  next_state = S_ERR;
               end else begin
                  n_guess    = mid_sum[4:1];
                  n_wcnt     = WLOAD;
                  next_state = HAS_WAIT ? S_WAIT : S_CMP;
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Status outputs decoded from the registered state
   always_comb begin
      busy = (state == S_WAIT) || (state == S_CMP);
      done = (state == S_DONE);
      err  = (state == S_ERR);
   end

endmodule
